bsg_cache_trace_driver_32: RTL

- Trace-driven initiator for the bsg_cache 32-bit packet interface. It is the sending end of the port that the cache-side checker monitors.
- Reads a combinational trace ROM, issues bsg_cache_pkt_s packets on a valid/ready handshake and consumes data responses.
- Tracks outstanding requests, supports fences and idle delays, and reports completion and protocol errors to the testbench.

---
 rtl/bsg_cache_trace_driver_32.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bsg_cache_trace_driver_32.sv
// Trace-driven initiator for the bsg_cache 32-bit packet interface.
// Walks a combinational trace ROM and issues cache packets on a valid/ready
// handshake. It also consumes responses, tracks the number of in-flight
// requests, and handles FENCE/DELAY/FINISH trace commands.
//
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   en_i                    issue enable (responses are consumed regardless)
//   rom_addr_o/rom_data_i   trace ROM read port, entry = {cmd[3:0], pkt}
//   cache_pkt_o/v_o/ready_i packet request handshake
//   data_i/v_i/yumi_o       response handshake (data_i is for the checker only)
//   done_o                  trace finished and nothing outstanding
//   error_o                 sticky protocol error
//   sent_count_o            packets accepted by the cache
//   recv_count_o            responses consumed
module bsg_cache_trace_driver_32
  #(parameter int unsigned data_width_p     = 32
  , parameter int unsigned addr_width_p     = 32
  , parameter int unsigned rom_addr_width_p = 10
  , parameter int unsigned max_out_p        = 8
  // bsg_cache_pkt_s = {opcode[5:0], addr, data, mask[data_width_p/8-1:0]}
  , localparam int unsigned cache_pkt_width_lp = 6 + addr_width_p + data_width_p + data_width_p/8
  )
  (input  logic                            clk_i
  , input  logic                           reset_n_i
  , input  logic                           en_i
  , output logic [rom_addr_width_p-1:0]    rom_addr_o
  , input  logic [4+cache_pkt_width_lp-1:0] rom_data_i
  , output logic [cache_pkt_width_lp-1:0]  cache_pkt_o
  , output logic                           v_o
  , input  logic                           ready_i
  , input  logic [data_width_p-1:0]        data_i
  , input  logic                           v_i
  , output logic                           yumi_o
  , output logic                           done_o
  , output logic                           error_o
  , output logic [31:0]                    sent_count_o
  , output logic [31:0]                    recv_count_o
  );

  localparam int unsigned out_width_lp   = $clog2(max_out_p + 1);
  localparam int unsigned entry_width_lp = 4 + cache_pkt_width_lp;

  localparam logic [3:0] cmd_nop_lp    = 4'd0;
  localparam logic [3:0] cmd_send_lp   = 4'd1;
  localparam logic [3:0] cmd_fence_lp  = 4'd2;
  localparam logic [3:0] cmd_delay_lp  = 4'd3;
  localparam logic [3:0] cmd_finish_lp = 4'd4;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_FENCE = 2'd1,
    S_DELAY = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [rom_addr_width_p-1:0]   ptr_q,   ptr_d;
  logic [out_width_lp-1:0]       out_q,   out_d;
  logic [7:0]                    dly_q,   dly_d;
  logic [31:0]                   sent_q,  sent_d;
  logic [31:0]                   recv_q,  recv_d;
  logic                          err_q,   err_d;
  logic                          done_q,  done_d;

  logic [3:0] cmd;
  logic [7:0] dly_arg;
  logic       v_c;
  logic       accept;
  logic       yumi;
  logic       advance;

  // data_i only passes by this block on its way to the checker
  logic unused_data;
  assign unused_data = ^data_i;

  // Next-state, handshake and bookkeeping
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    dly_d   = dly_q;
    err_d   = err_q;
    v_c     = 1'b0;
    advance = 1'b0;

    cmd     = rom_data_i[entry_width_lp-1 -: 4];
    dly_arg = rom_data_i[7:0];
    // Outputs are forced to their reset values while reset is held
    yumi    = v_i & reset_n_i;

    unique case (state_q)
      S_ISSUE: begin
        if (en_i) begin
          case (cmd)
            cmd_nop_lp:    advance = 1'b1;
            cmd_send_lp: begin
              v_c     = (out_q < out_width_lp'(max_out_p));
              advance = v_c & ready_i;
            end
            cmd_fence_lp:  state_d = S_FENCE;
            cmd_delay_lp: begin
              // The decode cycle is the first stall cycle, so 0 and 1 both
              // cost exactly one cycle.
              if (dly_arg <= 8'd1) begin
                advance = 1'b1;
              end else begin
                dly_d   = dly_arg - 8'd1;
                state_d = S_DELAY;
              end
            end
            cmd_finish_lp: state_d = S_DONE;
            default: begin
              advance = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_FENCE: begin
        // Release in the same cycle the last response is consumed
        if ((out_q == '0) || ((out_q == out_width_lp'(1)) && yumi)) begin
          advance = 1'b1;
        end
      end
      S_DELAY: begin
        if (dly_q <= 8'd1) begin
          advance = 1'b1;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
    endcase

    // Stepping past the last ROM entry ends the trace instead of wrapping
    if (advance) begin
      if (ptr_q == '1) begin
        state_d = S_DONE;
      end else begin
        ptr_d   = ptr_q + rom_addr_width_p'(1);
        state_d = S_ISSUE;
      end
    end

    accept = v_c & reset_n_i & ready_i;

    if (yumi && (out_q == '0)) begin
      err_d = 1'b1;
    end
    if (accept && !yumi) begin
      out_d = out_q + out_width_lp'(1);
    end else if (yumi && !accept && (out_q != '0)) begin
      out_d = out_q - out_width_lp'(1);
    end

    sent_d = sent_q + 32'(accept);
    recv_d = recv_q + 32'(yumi);
    done_d = (state_q == S_DONE) && (out_d == '0);
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_ISSUE;
      ptr_q   <= '0;
      out_q   <= '0;
      dly_q   <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      dly_q   <= dly_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr_o   = ptr_q;
  assign cache_pkt_o  = rom_data_i[cache_pkt_width_lp-1:0];
  assign v_o          = v_c & reset_n_i;
  assign yumi_o       = yumi;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign sent_count_o = sent_q;
  assign recv_count_o = recv_q;

endmodule
